// File: rtl/booth_seq_divider_pkg.sv
// Shared definitions for the tile arithmetic unit (divider and Booth multiplier).
package booth_seq_divider_pkg;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        FIX  = 2'd3
    } state_t;

endpackage

// File: rtl/booth_seq_divider_if.sv
// Start/done handshake and operand/result bus of the sequential divider.
interface booth_seq_divider_if #(parameter int N = 4);

    logic             ena;
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_zero;
    logic             overflow;

    modport master (
        output ena, start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  ena, start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero, overflow
    );

endinterface

// File: rtl/booth_seq_divider_twos_abs_neg.sv
// Combinational conditional two's-complement negate; with neg_i = sign bit it yields |a|.
module twos_abs_neg #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + W'(1)) : a_i;

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module booth_seq_divider
    import booth_seq_divider_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_seq_divider_if.slave   bus
);

    localparam int QW = 2 * N;
    localparam int CW = $clog2(QW);

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [QW-1:0]   dq_q;
    logic [N-1:0]    rem_q;
    logic [N:0]      dvs_q;
    logic            sd_q, ss_q, dz_q, ov_q;
    logic            busy_q, done_q, dz_out_q, ov_out_q;
    logic [QW-1:0]   quot_q;
    logic [N-1:0]    rem_out_q;

    logic [QW:0]     dvd_ext, dvd_mag;
    logic [N:0]      dvs_ext, dvs_mag;
    logic [N:0]      sh;
    logic [N+1:0]    trial;
    logic [N-1:0]    rem_d;
    logic [QW-1:0]   dq_d;
    logic [QW-1:0]   q_fix;
    logic [N-1:0]    r_fix;
    logic            is_dz, is_ov;
    logic            unused_ok;

    // Magnitudes are one bit wider so the most negative operands have a positive form.
    assign dvd_ext = {bus.dividend[QW-1], bus.dividend};
    assign dvs_ext = {bus.divisor[N-1], bus.divisor};

    twos_abs_neg #(.W(QW+1)) u_dvd_abs (.a_i(dvd_ext), .neg_i(bus.dividend[QW-1]), .y_o(dvd_mag));
    twos_abs_neg #(.W(N+1))  u_dvs_abs (.a_i(dvs_ext), .neg_i(bus.divisor[N-1]),   .y_o(dvs_mag));
    twos_abs_neg #(.W(QW))   u_q_fix   (.a_i(dq_q),    .neg_i(sd_q ^ ss_q),        .y_o(q_fix));
    twos_abs_neg #(.W(N))    u_r_fix   (.a_i(rem_q),   .neg_i(sd_q),               .y_o(r_fix));

    assign is_dz = (bus.divisor == '0);
    assign is_ov = (bus.dividend == {1'b1, {(QW-1){1'b0}}}) && (bus.divisor == '1);

    // Partial remainder stays below |divisor| <= 2^(N-1), so N bits hold it between steps.
    assign sh    = {rem_q, dq_q[QW-1]};
    assign trial = {1'b0, sh} - {1'b0, dvs_q};
    assign rem_d = trial[N+1] ? sh[N-1:0] : trial[N-1:0];
    assign dq_d  = {dq_q[QW-2:0], ~trial[N+1]};

    assign unused_ok = &{1'b0, dvd_mag[QW], trial[N]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dq_q      <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            sd_q      <= 1'b0;
            ss_q      <= 1'b0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_out_q  <= 1'b0;
            ov_out_q  <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
        end else if (bus.ena) begin
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q  <= LOAD;
                        dz_out_q <= 1'b0;
                        ov_out_q <= 1'b0;
                    end
                end
                LOAD: begin
                    busy_q <= 1'b1;
                    sd_q   <= bus.dividend[QW-1];
                    ss_q   <= bus.divisor[N-1];
                    dvs_q  <= dvs_mag;
                    dz_q   <= is_dz;
                    ov_q   <= is_ov;
                    cnt_q  <= '0;
                    dq_q   <= dvd_mag[QW-1:0];
                    if (is_dz) begin
                        // Raw low dividend bits become the remainder on divide-by-zero.
                        rem_q   <= bus.dividend[N-1:0];
                        state_q <= FIX;
                    end else begin
                        rem_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dq_q  <= dq_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(QW - 1))
                        state_q <= FIX;
                end
                FIX: begin
                    done_q    <= 1'b1;
                    quot_q    <= dz_q ? '1 : q_fix;
                    rem_out_q <= dz_q ? rem_q : r_fix;
                    dz_out_q  <= dz_q;
                    ov_out_q  <= ov_q;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_out_q;
    assign bus.div_zero  = dz_out_q;
    assign bus.overflow  = ov_out_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Scoreboard bench for booth_seq_divider: directed vectors, control corner cases, exhaustive sweep.
module tb_booth_seq_divider;

    localparam int N = 4;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        logic       ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    booth_seq_divider_if #(.N(N)) bus();
    booth_seq_divider #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t exp_q[$];
    int   n_chk = 0, n_pass = 0, n_done = 0, n_exp = 0;
    int   cyc = 0, t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    endtask

    function automatic exp_t mk(input logic [7:0] q, input logic [3:0] r, input logic dz, input logic ov);
        mk = {q, r, dz, ov};
    endfunction

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                chk("spurious_done", n_done, n_exp);
            end else begin
                e = exp_q.pop_front();
                chk("result", {bus.quotient, bus.remainder, bus.div_zero, bus.overflow}, e);
            end
        end
    end

    task automatic launch(input logic [7:0] dvd, input logic [3:0] dvs, input exp_t e, input bit push);
        if (push) begin
            exp_q.push_back(e);
            n_exp++;
        end
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output int lat, output int bsy);
        int n;
        n = 0;
        bsy = 0;
        while (!bus.done && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.busy) bsy++;
        end
        lat = cyc - t0;
    endtask

    task automatic run(input logic [7:0] dvd, input logic [3:0] dvs, input exp_t e, input int want_lat);
        int lat, bsy;
        launch(dvd, dvs, e, 1'b1);
        wait_done(lat, bsy);
        chk("latency", lat, want_lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int lat, bsy;
        bus.ena = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero, bus.overflow}, 0);
        rst_n = 1'b1;
        bus.ena = 1'b1;
        @(negedge clk);

        // 100 / 7 with latency and busy window
        launch(8'h64, 4'h7, mk(8'h0E, 4'h2, 1'b0, 1'b0), 1'b1);
        chk("busy_at_accept", bus.busy, 0);
        wait_done(lat, bsy);
        chk("latency_100_7", lat, 10);
        chk("busy_cycles", bsy, 10);
        @(negedge clk);
        chk("busy_after_done", {bus.busy, bus.done}, 0);

        // Sign matrix
        run(8'h9C, 4'h7, mk(8'hF2, 4'hE, 1'b0, 1'b0), 10);
        run(8'h64, 4'h9, mk(8'hF2, 4'h2, 1'b0, 1'b0), 10);
        run(8'h9C, 4'h9, mk(8'h0E, 4'hE, 1'b0, 1'b0), 10);

        // Overflow, then flag cleared on the next division
        run(8'h80, 4'hF, mk(8'h80, 4'h0, 1'b0, 1'b1), 10);
        run(8'h80, 4'h8, mk(8'h10, 4'h0, 1'b0, 1'b0), 10);

        // Divide by zero skips the iterations
        run(8'h37, 4'h0, mk(8'hFF, 4'h7, 1'b1, 1'b0), 2);
        run(8'h07, 4'h2, mk(8'h03, 4'h1, 1'b0, 1'b0), 10);

        // start while busy is ignored
        launch(8'h64, 4'h7, mk(8'h0E, 4'h2, 1'b0, 1'b0), 1'b1);
        repeat (3) @(negedge clk);
        bus.dividend = 8'h09;
        bus.divisor  = 4'h3;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, bsy);
        chk("latency_busy_start", lat, 10);
        repeat (15) @(negedge clk);
        chk("done_count_busy_start", n_done, n_exp);

        // ena=0 for 5 cycles mid-run
        launch(8'h64, 4'h7, mk(8'h0E, 4'h2, 1'b0, 1'b0), 1'b1);
        repeat (3) @(negedge clk);
        bus.ena = 1'b0;
        repeat (5) @(negedge clk);
        bus.ena = 1'b1;
        wait_done(lat, bsy);
        chk("latency_ena_hold", lat, 15);

        // Reset during CALC aborts the run
        launch(8'h9C, 4'h7, mk(8'h00, 4'h0, 1'b0, 1'b0), 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_mid_calc", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero, bus.overflow}, 0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("done_count_after_abort", n_done, n_exp);
        run(8'h64, 4'h7, mk(8'h0E, 4'h2, 1'b0, 1'b0), 10);

        // Exhaustive sweep against the language operators
        for (int a = -128; a < 128; a++) begin
            for (int b = -8; b < 8; b++) begin
                int q, r;
                logic [31:0] qv, rv;
                if (b == 0) continue;
                q = a / b;
                r = a % b;
                qv = q;
                rv = r;
                run(a[7:0], b[3:0], mk(qv[7:0], rv[3:0], 1'b0, (a == -128) && (b == -1)), 10);
            end
        end

        repeat (5) @(negedge clk);
        chk("done_count_final", n_done, n_exp);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
